// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared types, default geometry/timing and helpers for the DRAM request sequencer
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACT,
    WR,
    RD,
    PRE
  } state_t;

  localparam int DEF_NUM_OF_BANKS = 8;
  localparam int DEF_NUM_OF_ROWS  = 128;
  localparam int DEF_NUM_OF_COLS  = 8;
  localparam int DEF_DATA_WIDTH   = 1;

  localparam int DEF_T_RCD = 2;
  localparam int DEF_CL    = 1;
  localparam int DEF_T_RP  = 2;

  // Wide enough for any practical wait; the timer only ever counts down.
  localparam int CNT_W = 8;

  typedef struct packed {
    logic                                rw;
    logic [$clog2(DEF_NUM_OF_BANKS)-1:0] bank;
    logic [$clog2(DEF_NUM_OF_ROWS)-1:0]  row;
    logic [$clog2(DEF_NUM_OF_COLS)-1:0]  col;
    logic [DEF_DATA_WIDTH-1:0]           wdata;
  } req_t;

  // A wait of N cycles is a load of N-1: the loaded cycle itself counts as the first.
  function automatic logic [CNT_W-1:0] wait_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/dram_timer.sv
// rtl/dram_timer.sv - loadable down-counter with a zero flag for the activate/read/precharge waits
module dram_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins; otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dram_req_sequencer.sv
// rtl/dram_req_sequencer.sv - host request to bank/row/col DRAM pin sequencer (OPEN_PAGE_EN: open-page row table)
module dram_req_sequencer
  import dram_pkg::*;
#(
  parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
  parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int T_RCD        = DEF_T_RCD,
  parameter int CL           = DEF_CL,
  parameter int T_RP         = DEF_T_RP,
  localparam int BW = $clog2(NUM_OF_BANKS),
  localparam int RW = $clog2(NUM_OF_ROWS),
  localparam int CW = $clog2(NUM_OF_COLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [BW-1:0]         req_bank,
  input  logic [RW-1:0]         req_row,
  input  logic [CW-1:0]         req_col,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  dram_rw,
  output logic [BW-1:0]         dram_bank_id,
  output logic [RW-1:0]         dram_rowid,
  output logic [CW-1:0]         dram_colid,
  inout  wire  [DATA_WIDTH-1:0] dram_data
);

  state_t           state, next_state;
  req_t             req_q;
  logic             handshake;
  logic             rd_issued;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             resp_fire;
  logic             capture_rd;

  assign req_ready = (state == IDLE);
  assign handshake = req_valid && req_ready;

  // The latched request drives the pins, so they hold until the next capture.
  assign dram_bank_id = req_q.bank;
  assign dram_rowid   = req_q.row;
  assign dram_colid   = req_q.col;

  // Write strobe exists only in WR; the bus is released in every other state.
  assign dram_rw   = (state == WR);
  assign dram_data = dram_rw ? req_q.wdata : {DATA_WIDTH{1'bz}};

  dram_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

`ifdef OPEN_PAGE_EN
  logic [NUM_OF_BANKS-1:0] open_vld;
  logic [RW-1:0]           open_row [NUM_OF_BANKS];
  logic                    bank_open;
  logic                    row_hit;

  assign bank_open = open_vld[req_bank];
  assign row_hit   = bank_open && (open_row[req_bank] == req_row);

  // Record the row as open once its activate wait completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      open_vld <= '0;
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        open_row[b] <= '0;
      end
    end else if (state == ACT && tmr_zero) begin
      open_vld[req_q.bank] <= 1'b1;
      open_row[req_q.bank] <= req_q.row;
    end
  end
`endif

  // Next-state decode, timer loads for the coming wait, and response/capture strobes.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    resp_fire  = 1'b0;
    capture_rd = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
`ifdef OPEN_PAGE_EN
          if (row_hit) begin
            next_state = req_rw ? WR : RD;
          end else if (bank_open) begin
            next_state = PRE;
            tmr_load   = 1'b1;
            tmr_val    = wait_load(T_RP);
          end else begin
            next_state = ACT;
            tmr_load   = 1'b1;
            tmr_val    = wait_load(T_RCD);
          end
`else
          next_state = ACT;
          tmr_load   = 1'b1;
          tmr_val    = wait_load(T_RCD);
`endif
        end
      end
      ACT: begin
        if (tmr_zero) begin
          next_state = req_q.rw ? WR : RD;
        end
      end
      WR: begin
`ifdef OPEN_PAGE_EN
        next_state = IDLE;
        resp_fire  = 1'b1;
`else
        next_state = PRE;
        tmr_load   = 1'b1;
        tmr_val    = wait_load(T_RP);
`endif
      end
      RD: begin
        if (!rd_issued) begin
          tmr_load = 1'b1;
          tmr_val  = wait_load(CL);
        end else if (tmr_zero) begin
          capture_rd = 1'b1;
`ifdef OPEN_PAGE_EN
          next_state = IDLE;
          resp_fire  = 1'b1;
`else
          next_state = PRE;
          tmr_load   = 1'b1;
          tmr_val    = wait_load(T_RP);
`endif
        end
      end
      PRE: begin
        if (tmr_zero) begin
`ifdef OPEN_PAGE_EN
          next_state = ACT;
          tmr_load   = 1'b1;
          tmr_val    = wait_load(T_RCD);
`else
          next_state = IDLE;
          resp_fire  = 1'b1;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, request capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_issued  <= 1'b0;
      req_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= next_state;
      rd_issued  <= (state == RD) && (next_state == RD);
      resp_valid <= resp_fire;
      if (handshake) begin
        req_q <= '{rw: req_rw, bank: req_bank, row: req_row, col: req_col, wdata: req_wdata};
      end
      if (state == WR) begin
        resp_rdata <= '0;
      end else if (capture_rd) begin
        resp_rdata <= dram_data;
      end
    end
  end

endmodule

// File: tb/tb_dram_req_sequencer.sv
// tb/tb_dram_req_sequencer.sv - directed self-checking bench with a bank/row/col DRAM model
module tb_dram_req_sequencer;

  localparam int T_RCD = 2;
  localparam int CL    = 1;
  localparam int T_RP  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [2:0] req_bank;
  logic [6:0] req_row;
  logic [2:0] req_col;
  logic [0:0] req_wdata;
  logic       resp_valid;
  logic [0:0] resp_rdata;
  logic       dram_rw;
  logic [2:0] dram_bank_id;
  logic [6:0] dram_rowid;
  logic [2:0] dram_colid;
  wire  [0:0] dram_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  dram_req_sequencer #(
    .NUM_OF_BANKS (8),
    .NUM_OF_ROWS  (128),
    .NUM_OF_COLS  (8),
    .DATA_WIDTH   (1),
    .T_RCD        (T_RCD),
    .CL           (CL),
    .T_RP         (T_RP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_bank     (req_bank),
    .req_row      (req_row),
    .req_col      (req_col),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .dram_rw      (dram_rw),
    .dram_bank_id (dram_bank_id),
    .dram_rowid   (dram_rowid),
    .dram_colid   (dram_colid),
    .dram_data    (dram_data)
  );

  // DRAM model: stores on the write strobe, drives the addressed cell when enabled and not written.
  bit   mem [0:7][0:127][0:7];
  logic bfm_en = 1'b0;

  assign dram_data = (bfm_en && dram_rw !== 1'b1) ? mem[dram_bank_id][dram_rowid][dram_colid] : 1'bz;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dram_rw === 1'b1) mem[dram_bank_id][dram_rowid][dram_colid] <= dram_data[0];
  end

  // Pin monitor: strobe count and address, bus contention, response count.
  int         strobes  = 0;
  int         bus_bad  = 0;
  int         resp_cnt = 0;
  logic [2:0] s_bank;
  logic [6:0] s_row;
  logic [2:0] s_col;

  always @(negedge clk) begin
    if (dram_rw === 1'b1) begin
      strobes++;
      s_bank = dram_bank_id;
      s_row  = dram_rowid;
      s_col  = dram_colid;
    end
    if (bfm_en && dram_rw !== 1'b1 && $isunknown(dram_data)) bus_bad++;
    if (resp_valid === 1'b1) resp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected handshake-to-response latency, tracking open rows when the open-page build is used.
`ifdef OPEN_PAGE_EN
  bit tb_open_v [0:7];
  int tb_open_r [0:7];
`endif

  function automatic int exp_lat(input bit rw, input int b, input int r);
    int acc;
    int l;
    acc = rw ? 1 : 1 + CL;
`ifdef OPEN_PAGE_EN
    if (tb_open_v[b] && tb_open_r[b] == r) l = acc;
    else if (tb_open_v[b]) l = T_RP + T_RCD + acc;
    else l = T_RCD + acc;
    tb_open_v[b] = 1'b1;
    tb_open_r[b] = r;
`else
    l = T_RCD + acc + T_RP;
    if (b < 0 || r < 0) l = -1;
`endif
    return l;
  endfunction

  task automatic clear_open();
`ifdef OPEN_PAGE_EN
    for (int b = 0; b < 8; b++) tb_open_v[b] = 1'b0;
`endif
  endtask

  // Present a request, wait for the handshake edge, then scramble the inputs.
  task automatic send(input bit rw, input int b, input int r, input int c, input bit wd, output int h);
    int g = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_bank  = 3'(b);
    req_row   = 7'(r);
    req_col   = 3'(c);
    req_wdata = wd;
    while (req_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("handshake_bound", 32'(g < 50), 32'd1);
    @(posedge clk);
    #1;
    h         = cyc;
    req_valid = 1'b0;
    req_rw    = 1'($urandom);
    req_bank  = 3'($urandom);
    req_row   = 7'($urandom);
    req_col   = 3'($urandom);
    req_wdata = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic wait_resp(input int h, output int lat);
    int g = 0;
    while (resp_valid !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    lat = (g < 50) ? cyc - h : -1;
  endtask

  initial begin
    int h, hprev, lat, g, s0, b0, r0;
    logic [7:0] pat;

    rst = 1'b1;
    req_valid = 1'b0;
    req_rw = 1'b0;
    req_bank = '0;
    req_row = '0;
    req_col = '0;
    req_wdata = '0;

    // 1: reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_dram_rw", 32'(dram_rw), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_bank_pins", {25'd0, dram_bank_id, dram_rowid[3:0]}, 32'd0);
    n_cmp++;
    assert (dram_data === 1'bz) else begin
      n_err++;
      $error("FAIL rst_bus_z: observed %b expected z", dram_data);
    end
    rst = 1'b0;
    @(negedge clk);

    // 2: write b3 r17 c5 d=1
    s0 = strobes;
    send(1'b1, 3, 17, 5, 1'b1, h);
    wait_resp(h, lat);
    check("wr_latency", 32'(lat), 32'(exp_lat(1'b1, 3, 17)));
    #1;
    check("wr_strobe_count", 32'(strobes - s0), 32'd1);
    check("wr_strobe_pins", {16'd0, 1'b0, s_bank, 1'b0, s_row, 1'b0, s_col}, {16'd0, 1'b0, 3'd3, 1'b0, 7'd17, 1'b0, 3'd5});
    check("wr_mem_stored", 32'(mem[3][17][5]), 32'd1);
    check("wr_resp_rdata", 32'(resp_rdata), 32'd0);
    @(negedge clk);

    // 3: read back with the model driving the bus
    bfm_en = 1'b1;
    s0 = strobes;
    b0 = bus_bad;
    send(1'b0, 3, 17, 5, 1'b0, h);
    wait_resp(h, lat);
    check("rd_latency", 32'(lat), 32'(exp_lat(1'b0, 3, 17)));
    check("rd_resp_rdata", 32'(resp_rdata), 32'd1);
    #1;
    check("rd_no_strobe", 32'(strobes - s0), 32'd0);
    check("rd_no_contention", 32'(bus_bad - b0), 32'd0);
    @(negedge clk);

    // 4: back-to-back writes c0..c7 on b0 r0, then back-to-back reads
    pat = 8'b10110010;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) check("wr_b2b_ready_with_resp", {30'd0, req_ready, resp_valid}, 32'd3);
      send(1'b1, 0, 0, i, pat[7-i], h);
      lat = exp_lat(1'b1, 0, 0);
      if (i > 0) check("wr_b2b_gap", 32'(h - hprev), 32'(lat + 1));
      wait_resp(h, g);
      check("wr_b2b_latency", 32'(g), 32'(lat));
      hprev = h;
    end
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 0, 0, i, 1'b0, h);
      lat = exp_lat(1'b0, 0, 0);
      if (i > 0) check("rd_b2b_gap", 32'(h - hprev), 32'(lat + 1));
      wait_resp(h, g);
      check("rd_b2b_latency", 32'(g), 32'(lat));
      check("rd_b2b_data", 32'(resp_rdata), 32'(pat[7-i]));
      hprev = h;
    end
    @(negedge clk);

    // 5: reset during the write strobe
    send(1'b1, 2, 5, 3, 1'b1, h);
    g = 0;
    while (dram_rw !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("rstwr_strobe_seen", 32'(dram_rw), 32'd1);
    r0 = resp_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstwr_dram_rw", 32'(dram_rw), 32'd0);
    check("rstwr_idle", 32'(req_ready), 32'd1);
    check("rstwr_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    clear_open();
    repeat (10) @(negedge clk);
    #1;
    check("rstwr_no_resp", 32'(resp_cnt - r0), 32'd0);
    send(1'b0, 3, 17, 5, 1'b0, h);
    wait_resp(h, lat);
    check("rstwr_next_latency", 32'(lat), 32'(exp_lat(1'b0, 3, 17)));
    check("rstwr_next_data", 32'(resp_rdata), 32'd1);
    @(negedge clk);

`ifdef OPEN_PAGE_EN
    // 6: closed bank, row hit, row miss
    send(1'b0, 1, 4, 0, 1'b0, h);
    wait_resp(h, lat);
    check("op_closed_latency", 32'(lat), 32'd4);
    @(negedge clk);
    send(1'b0, 1, 4, 0, 1'b0, h);
    wait_resp(h, lat);
    check("op_hit_latency", 32'(lat), 32'd2);
    @(negedge clk);
    send(1'b0, 1, 9, 0, 1'b0, h);
    wait_resp(h, lat);
    check("op_miss_latency", 32'(lat), 32'(2 + T_RP + T_RCD));
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
